// File: rtl/i2c_bit_pkg.sv
// rtl/i2c_bit_pkg.sv - command encodings, phase states and SCL/SDA drive tables
package i2c_bit_pkg;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH_A = 3'd1,
        PH_B = 3'd2,
        PH_C = 3'd3,
        PH_D = 3'd4
    } state_t;

    // Each command owns a 4-bit nibble indexed by {cmd, phase}; within a
    // nibble bit 0 is PH_A and bit 3 is PH_D. WRITE SDA comes from wr_bit,
    // so its SDA nibble is unused.
    localparam logic [15:0] SCL_TABLE = {4'b0110, 4'b0110, 4'b1110, 4'b0111};
    localparam logic [15:0] SDA_TABLE = {4'b1111, 4'b0000, 4'b1000, 4'b0011};

    function automatic logic [1:0] phase_idx(input state_t s);
        case (s)
            PH_B:    phase_idx = 2'd1;
            PH_C:    phase_idx = 2'd2;
            PH_D:    phase_idx = 2'd3;
            default: phase_idx = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/i2c_qtr_timer.sv
// rtl/i2c_qtr_timer.sv - quarter-period down-counter with load, stall and zero flag
module i2c_qtr_timer #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             stall,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load wins over counting; a stalled or exhausted counter holds its value.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (!stall && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/i2c_bit_engine.sv
// rtl/i2c_bit_engine.sv - I2C bit-level engine: START/STOP/WRITE/READ with stretch and arbitration
module i2c_bit_engine
    import i2c_bit_pkg::*;
#(
    parameter int CNT_W        = 10,
    parameter int DEF_PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] prescale,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd,
    input  logic             wr_bit,
    output logic             done,
    output logic             rd_bit,
    output logic             arb_lost,
    output logic             busy,
    output logic             scl_o,
    output logic             sda_o,
    input  logic             scl_i,
    input  logic             sda_i
);

    state_t           state, state_n;
    logic [1:0]       cmd_q;
    logic             wr_bit_q;
    logic [CNT_W-1:0] prescale_q;
    logic [1:0]       ph;
    logic             accept;
    logic             stretch_en;
    logic             stall;
    logic             zero;
    logic             advance;
    logic             last_c;
    logic             arb_hit;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;

    assign cmd_ready  = (state == IDLE);
    assign busy       = ~cmd_ready;
    assign accept     = cmd_valid & cmd_ready;
    assign ph         = phase_idx(state);

    // Stretching only matters where the master has released SCL expecting it high:
    // PH_B of clocked commands, and anywhere in START.
    assign stretch_en = (state == PH_B) | (cmd_q == CMD_START);
    assign stall      = busy & stretch_en & scl_o & ~scl_i;
    assign advance    = busy & zero & ~stall;
    assign last_c     = advance & (state == PH_C);
    assign arb_hit    = last_c & (cmd_q == CMD_WRITE) & wr_bit_q & ~sda_i;

    // The first phase of a command uses the live prescale; later phases reuse the latched copy.
    assign tmr_load   = accept | advance;
    assign tmr_val    = accept ? prescale : prescale_q;

    i2c_qtr_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .stall    (stall),
        .zero     (zero)
    );

    // Phase state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next phase: walk A-B-C-D-IDLE on each timer expiry; lost arbitration skips PH_D.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept)  state_n = PH_A;
            PH_A:    if (advance) state_n = PH_B;
            PH_B:    if (advance) state_n = PH_C;
            PH_C:    if (advance) state_n = arb_hit ? IDLE : PH_D;
            PH_D:    if (advance) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Line drive lookup; both lines are released whenever the engine is idle.
    always_comb begin
        scl_o = 1'b1;
        sda_o = 1'b1;
        if (busy) begin
            scl_o = SCL_TABLE[{cmd_q, ph}];
            sda_o = (cmd_q == CMD_WRITE) ? wr_bit_q : SDA_TABLE[{cmd_q, ph}];
        end
    end

    // Command capture on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q      <= CMD_START;
            wr_bit_q   <= 1'b0;
            prescale_q <= CNT_W'(DEF_PRESCALE);
        end else if (accept) begin
            cmd_q      <= cmd;
            wr_bit_q   <= wr_bit;
            prescale_q <= prescale;
        end
    end

    // Completion pulses land in the first IDLE cycle; rd_bit holds between samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            done     <= 1'b0;
            arb_lost <= 1'b0;
            rd_bit   <= 1'b0;
        end else begin
            done     <= (advance & (state == PH_D)) | arb_hit;
            arb_lost <= arb_hit;
            if (last_c && cmd_q == CMD_READ) begin
                rd_bit <= sda_i;
            end
        end
    end

endmodule

// File: tb/tb_i2c_bit_engine.sv
// tb/tb_i2c_bit_engine.sv - directed self-checking bench for i2c_bit_engine
module tb_i2c_bit_engine;
    import i2c_bit_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] prescale;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic       wr_bit;
    logic       done;
    logic       rd_bit;
    logic       arb_lost;
    logic       busy;
    logic       scl_o;
    logic       sda_o;
    logic       scl_i;
    logic       sda_i;

    logic       scl_force = 1'b0;
    logic       sda_low   = 1'b0;

    // Open-drain bus: a line is low if anyone pulls it low.
    assign scl_i = scl_o & ~scl_force;
    assign sda_i = sda_o & ~sda_low;

    always #5 clk = ~clk;

    i2c_bit_engine dut (
        .clk       (clk),
        .reset     (reset),
        .prescale  (prescale),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .wr_bit    (wr_bit),
        .done      (done),
        .rd_bit    (rd_bit),
        .arb_lost  (arb_lost),
        .busy      (busy),
        .scl_o     (scl_o),
        .sda_o     (sda_o),
        .scl_i     (scl_i),
        .sda_i     (sda_i)
    );

    int   n_pass  = 0;
    int   n_total = 0;

    logic scl_tr  [0:255];
    logic sda_tr  [0:255];
    logic busy_tr [0:255];
    logic last_arb;
    logic last_rd;
    logic last_ready;
    int   s0;
    int   s_len = 0;
    int   lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Pack a traced line over cycles from..from+len-1, earliest cycle in bit 0.
    function automatic logic [31:0] pat(input bit use_sda, input int from, input int len);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < len; i++) r[i] = use_sda ? sda_tr[from+i] : scl_tr[from+i];
        return r;
    endfunction

    // Entered #1 after a posedge. Returns lat = cycles from accept cycle T to done, -1 on timeout.
    task automatic run_cmd(input logic [1:0] c, input logic b, input logic [9:0] p, output int l);
        int n;
        cmd       = c;
        wr_bit    = b;
        prescale  = p;
        cmd_valid = 1'b1;
        for (int g = 0; g < 100 && !cmd_ready; g++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wr_bit    = ~b;
        prescale  = 10'h3ff;
        l = -1;
        for (n = 1; n < 200; n++) begin
            scl_force = (n >= s0) && (n < s0 + s_len);
            #0;
            scl_tr[n]  = scl_o;
            sda_tr[n]  = sda_o;
            busy_tr[n] = busy;
            if (done) begin
                l          = n;
                last_arb   = arb_lost;
                last_rd    = rd_bit;
                last_ready = cmd_ready;
                break;
            end
            @(posedge clk); #1;
        end
        scl_force = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        prescale  = 10'd4;
        cmd_valid = 1'b0;
        cmd       = CMD_START;
        wr_bit    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;

        check("rst_scl", scl_o, 1);
        check("rst_sda", sda_o, 1);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_arb", arb_lost, 0);
        check("rst_rd", rd_bit, 0);

        // START, prescale 4
        run_cmd(CMD_START, 1'b0, 10'd4, lat);
        check("start_lat", lat, 21);
        check("start_sda_pre", sda_tr[10], 1);
        check("start_sda_fall", sda_tr[11], 0);
        check("start_scl_pre", scl_tr[15], 1);
        check("start_scl_fall", scl_tr[16], 0);
        check("start_busy_end", busy_tr[20], 1);
        check("start_busy_done", busy_tr[21], 0);

        // Back-to-back WRITE 1 then WRITE 0, prescale 0
        run_cmd(CMD_WRITE, 1'b1, 10'd0, lat);
        check("wr1_lat", lat, 5);
        check("wr1_ready", last_ready, 1);
        check("wr1_arb", last_arb, 0);
        check("wr1_sda", pat(1, 1, 4), 32'hf);
        check("wr1_scl", pat(0, 1, 4), 32'h6);
        run_cmd(CMD_WRITE, 1'b0, 10'd0, lat);
        check("wr0_lat", lat, 5);
        check("wr0_ready", last_ready, 1);
        check("wr0_sda", pat(1, 1, 4), 32'h0);
        check("wr0_scl", pat(0, 1, 4), 32'h6);

        // READ, prescale 2, slave drives 0 then 1
        sda_low = 1'b1;
        run_cmd(CMD_READ, 1'b0, 10'd2, lat);
        sda_low = 1'b0;
        check("rd0_lat", lat, 13);
        check("rd0_bit", last_rd, 0);
        check("rd0_sda", pat(1, 1, 12), 32'hfff);
        run_cmd(CMD_READ, 1'b0, 10'd2, lat);
        check("rd1_lat", lat, 13);
        check("rd1_bit", last_rd, 1);

        // Clock stretch: 10 cycles of SCL held low from PH_B entry (cycle 5 at prescale 3)
        run_cmd(CMD_WRITE, 1'b0, 10'd3, lat);
        check("nostr_lat", lat, 17);
        s0    = 5;
        s_len = 10;
        run_cmd(CMD_WRITE, 1'b0, 10'd3, lat);
        s_len = 0;
        check("str_lat", lat, 27);
        check("str_scl_rel", scl_tr[10], 1);

        // Arbitration loss: WRITE 1, prescale 1, SDA held low by another master
        sda_low = 1'b1;
        run_cmd(CMD_WRITE, 1'b1, 10'd1, lat);
        sda_low = 1'b0;
        check("arb_lat", lat, 7);
        check("arb_pulse", last_arb, 1);
        check("arb_scl", scl_tr[7], 1);
        check("arb_sda", sda_tr[7], 1);
        check("arb_busy_c", busy_tr[6], 1);

        // Reset during PH_B of STOP (prescale 4: PH_B spans cycles 6..10)
        cmd       = CMD_STOP;
        prescale  = 10'd4;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("stop_phb_scl", scl_o, 1);
        check("stop_phb_sda", sda_o, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mrst_busy", busy, 0);
        check("mrst_scl", scl_o, 1);
        check("mrst_sda", sda_o, 1);
        check("mrst_done", done, 0);
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            check("mrst_no_done", done, 0);
        end
        run_cmd(CMD_START, 1'b0, 10'd0, lat);
        check("post_start_lat", lat, 5);
        check("post_start_sda", pat(1, 1, 4), 32'h3);
        check("post_start_scl", pat(0, 1, 4), 32'h7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
